// File: rtl/mmm_pkg.sv
// Shared execution-pipeline types: branch encodings, the frontend resolution record
// and the branch unit's output-buffer record.
package mmm_pkg;

    localparam int XLEN        = 64;
    localparam int ROB_DEPTH   = 16;
    localparam int B_IMM       = 12;
    localparam int ROB_IDX_LEN = $clog2(ROB_DEPTH);

    typedef enum logic [5:0] {
        BR_BEQ  = 6'd0,
        BR_BNE  = 6'd1,
        BR_BLT  = 6'd2,
        BR_BGE  = 6'd3,
        BR_BLTU = 6'd4,
        BR_BGEU = 6'd5
    } branch_type_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic            taken;
        logic            mispredict;
    } resolution_t;

    typedef struct packed {
        resolution_t            res;
        logic [ROB_IDX_LEN-1:0] rob_idx;
        logic                   except;
    } bu_result_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: decides taken and flags encodings
// outside the defined branch types.
module branch_cond #(
    parameter int XLEN = mmm_pkg::XLEN
) (
    input  mmm_pkg::branch_type_t type_i,
    input  logic [XLEN-1:0]       rs1_i,
    input  logic [XLEN-1:0]       rs2_i,
    output logic                  taken_o,
    output logic                  illegal_o
);
    import mmm_pkg::*;

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (type_i)
            BR_BEQ:  taken_o = (rs1_i == rs2_i);
            BR_BNE:  taken_o = (rs1_i != rs2_i);
            BR_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
            BR_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
            BR_BLTU: taken_o = (rs1_i <  rs2_i);
            BR_BGEU: taken_o = (rs1_i >= rs2_i);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Conditional-branch execution unit: resolves one branch per cycle, pulses the
// frontend resolution record and holds a completion token for the CDB.
module branch_unit #(
    parameter int XLEN        = mmm_pkg::XLEN,
    parameter int ROB_IDX_LEN = $clog2(mmm_pkg::ROB_DEPTH)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  mmm_pkg::branch_type_t       branch_type_i,
    input  logic [XLEN-1:0]             pc_i,
    input  logic [XLEN-1:0]             rs1_value_i,
    input  logic [XLEN-1:0]             rs2_value_i,
    input  logic [mmm_pkg::B_IMM-1:0]   imm_i,
    input  logic                        pred_taken_i,
    input  logic [XLEN-1:0]             pred_target_i,
    input  logic [ROB_IDX_LEN-1:0]      rob_idx_i,
    output mmm_pkg::resolution_t        res_o,
    output logic                        cdb_valid_o,
    input  logic                        cdb_ready_i,
    output logic [ROB_IDX_LEN-1:0]      cdb_rob_idx_o,
    output logic                        cdb_except_o,
    output logic                        cdb_mispredict_o
);
    import mmm_pkg::*;

    logic            taken;
    logic            illegal;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_plus4;
    logic            except;
    logic            mispredict;
    logic            issue_accept;
    bu_result_t      new_result;

    logic            out_valid_q, out_valid_d;
    bu_result_t      result_q, result_d;

    branch_cond #(.XLEN(XLEN)) u_cond (
        .type_i    (branch_type_i),
        .rs1_i     (rs1_value_i),
        .rs2_i     (rs2_value_i),
        .taken_o   (taken),
        .illegal_o (illegal)
    );

    // The immediate holds offset bits [12:1]; bit 0 is implicitly zero.
    assign target   = pc_i + {{(XLEN-B_IMM-1){imm_i[B_IMM-1]}}, imm_i, 1'b0};
    assign pc_plus4 = pc_i + XLEN'(4);

    assign except     = illegal || (taken && (target[1:0] != 2'b00));
    assign mispredict = !except &&
                        ((taken != pred_taken_i) || (taken && (target != pred_target_i)));

    assign issue_ready_o = !out_valid_q || cdb_ready_i;
    assign issue_accept  = issue_valid_i && issue_ready_o && !flush_i;

    always_comb begin
        new_result                = '0;
        new_result.res.valid      = !except;
        new_result.res.pc         = pc_i;
        new_result.res.target     = taken ? target : pc_plus4;
        new_result.res.taken      = taken;
        new_result.res.mispredict = mispredict;
        new_result.rob_idx        = rob_idx_i;
        new_result.except         = except;
    end

    // The resolution valid bit is a one-cycle pulse; the CDB token is held until taken.
    always_comb begin
        out_valid_d            = out_valid_q;
        result_d               = result_q;
        result_d.res.valid     = 1'b0;
        if (flush_i) begin
            out_valid_d = 1'b0;
            result_d    = '0;
        end else if (issue_accept) begin
            out_valid_d = 1'b1;
            result_d    = new_result;
        end else if (cdb_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign res_o            = result_q.res;
    assign cdb_valid_o      = out_valid_q;
    assign cdb_rob_idx_o    = result_q.rob_idx;
    assign cdb_except_o     = result_q.except;
    assign cdb_mispredict_o = result_q.res.mispredict;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed cases from the branch rules plus
// randomized traffic under random CDB backpressure.
module tb_branch_unit;
    import mmm_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   rst_i = 1'b1;
    logic                   flush_i = 1'b0;
    logic                   issue_valid_i = 1'b0;
    logic                   issue_ready_o;
    branch_type_t           branch_type_i = BR_BEQ;
    logic [63:0]            pc_i = '0;
    logic [63:0]            rs1_value_i = '0;
    logic [63:0]            rs2_value_i = '0;
    logic [11:0]            imm_i = '0;
    logic                   pred_taken_i = 1'b0;
    logic [63:0]            pred_target_i = '0;
    logic [3:0]             rob_idx_i = '0;
    resolution_t            res_o;
    logic                   cdb_valid_o;
    logic                   cdb_ready_i = 1'b1;
    logic [3:0]             cdb_rob_idx_o;
    logic                   cdb_except_o;
    logic                   cdb_mispredict_o;

    branch_unit dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .issue_valid_i    (issue_valid_i),
        .issue_ready_o    (issue_ready_o),
        .branch_type_i    (branch_type_i),
        .pc_i             (pc_i),
        .rs1_value_i      (rs1_value_i),
        .rs2_value_i      (rs2_value_i),
        .imm_i            (imm_i),
        .pred_taken_i     (pred_taken_i),
        .pred_target_i    (pred_target_i),
        .rob_idx_i        (rob_idx_i),
        .res_o            (res_o),
        .cdb_valid_o      (cdb_valid_o),
        .cdb_ready_i      (cdb_ready_i),
        .cdb_rob_idx_o    (cdb_rob_idx_o),
        .cdb_except_o     (cdb_except_o),
        .cdb_mispredict_o (cdb_mispredict_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] target;
        logic        taken;
        logic        mispredict;
        int          cyc;
    } res_exp_t;

    typedef struct {
        logic [3:0] rob_idx;
        logic       except;
        logic       mispredict;
        int         cyc;
    } cdb_exp_t;

    res_exp_t res_q[$];
    cdb_exp_t cdb_q[$];
    bit       cdb_seen = 1'b0;
    int       cyc = 0;
    int       n_checks = 0;
    int       n_fail = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour straight from the branch rules, using plain integer arithmetic.
    function automatic void model(input logic [5:0] t, input logic [63:0] pc,
                                  input logic [63:0] rs1, input logic [63:0] rs2,
                                  input logic [11:0] imm, input logic pt,
                                  input logic [63:0] ptgt,
                                  output logic taken, output logic [63:0] res_tgt,
                                  output logic exc, output logic mis);
        longint signed   a = rs1;
        longint signed   b = rs2;
        longint unsigned ua = rs1;
        longint unsigned ub = rs2;
        logic signed [12:0] off13 = {imm, 1'b0};
        longint signed   off = off13;
        logic [63:0]     tgt;
        case (t)
            6'd0:    taken = (ua == ub);
            6'd1:    taken = (ua != ub);
            6'd2:    taken = (a < b);
            6'd3:    taken = (a >= b);
            6'd4:    taken = (ua < ub);
            6'd5:    taken = (ua >= ub);
            default: taken = 1'b0;
        endcase
        tgt     = pc + off;
        exc     = (t > 6'd5) || (taken && (tgt % 4 != 0));
        mis     = !exc && ((taken != pt) || (taken && tgt != ptgt));
        res_tgt = taken ? tgt : pc + 64'd4;
    endfunction

    task automatic issue(input logic [5:0] t, input logic [63:0] pc, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic [11:0] imm, input logic pt,
                         input logic [63:0] ptgt, input logic [3:0] rob, input bit rnd_ready);
        bit          ok = 1'b0;
        logic        taken, exc, mis;
        logic [63:0] rtgt;
        branch_type_i = branch_type_t'(t);
        pc_i = pc; rs1_value_i = rs1; rs2_value_i = rs2; imm_i = imm;
        pred_taken_i = pt; pred_target_i = ptgt; rob_idx_i = rob;
        issue_valid_i = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (issue_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
            if (rnd_ready) cdb_ready_i = 1'($urandom_range(0, 1));
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL issue_timeout: issue_ready stayed 0, expected 1 within 50 cycles");
        end else begin
            model(t, pc, rs1, rs2, imm, pt, ptgt, taken, rtgt, exc, mis);
            if (!exc) res_q.push_back('{pc, rtgt, taken, mis, cyc + 1});
            cdb_q.push_back('{rob, exc, mis, cyc + 1});
            @(posedge clk_i); #1;
        end
        issue_valid_i = 1'b0;
        if (rnd_ready) cdb_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    // Monitor: consumes resolution pulses and CDB completions as the DUT presents them.
    always @(negedge clk_i) begin
        if (res_o.valid) begin
            if (res_q.size() == 0) begin
                check("res_unexpected_pulse", 64'(res_o.valid), 64'd0);
            end else begin
                check("res_pc", res_o.pc, res_q[0].pc);
                check("res_target", res_o.target, res_q[0].target);
                check("res_taken", 64'(res_o.taken), 64'(res_q[0].taken));
                check("res_mispredict", 64'(res_o.mispredict), 64'(res_q[0].mispredict));
                check("res_cycle", 64'(cyc), 64'(res_q[0].cyc));
                void'(res_q.pop_front());
            end
        end
        if (cdb_valid_o) begin
            if (cdb_q.size() == 0) begin
                check("cdb_unexpected_valid", 64'(cdb_valid_o), 64'd0);
            end else begin
                check("cdb_rob_idx", 64'(cdb_rob_idx_o), 64'(cdb_q[0].rob_idx));
                check("cdb_except", 64'(cdb_except_o), 64'(cdb_q[0].except));
                check("cdb_mispredict", 64'(cdb_mispredict_o), 64'(cdb_q[0].mispredict));
                if (!cdb_seen) check("cdb_first_cycle", 64'(cyc), 64'(cdb_q[0].cyc));
                cdb_seen = 1'b1;
                if (cdb_ready_i && !flush_i && !rst_i) begin
                    void'(cdb_q.pop_front());
                    cdb_seen = 1'b0;
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_res_zero"}, 64'(res_o == '0), 64'd1);
        check({tag, "_cdb_valid"}, 64'(cdb_valid_o), 64'd0);
        check({tag, "_issue_ready"}, 64'(issue_ready_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(2);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("reset");
        check("reset_rob_idx", 64'(cdb_rob_idx_o), 64'd0);
        check("reset_except", 64'(cdb_except_o), 64'd0);
        check("reset_mispredict", 64'(cdb_mispredict_o), 64'd0);
        @(posedge clk_i); #1;

        // Taken, correct prediction
        issue(6'd0, 64'h100, 64'd5, 64'd5, 12'h008, 1'b1, 64'h110, 4'd1, 1'b0);
        // Signed vs unsigned direction
        issue(6'd2, 64'h200, '1, 64'd1, 12'h010, 1'b0, 64'h0, 4'd2, 1'b0);
        issue(6'd4, 64'h200, '1, 64'd1, 12'h010, 1'b0, 64'h0, 4'd3, 1'b0);
        // Negative offset wrapping below zero
        issue(6'd1, 64'h4, 64'd1, 64'd2, 12'hFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 4'd4, 1'b0);
        // Not-taken, predicted not-taken, garbage predicted target
        issue(6'd3, 64'h300, 64'd1, 64'd9, 12'h020, 1'b0, 64'hDEAD_BEEF, 4'd5, 1'b0);
        // Misaligned taken target and illegal type
        issue(6'd0, 64'h102, 64'd7, 64'd7, 12'h008, 1'b1, 64'h112, 4'd6, 1'b0);
        issue(6'h3F, 64'h400, 64'd7, 64'd7, 12'h008, 1'b1, 64'h410, 4'd7, 1'b0);
        idle(2);

        // Backpressure: one pulse, held CDB fields, then pass-through
        cdb_ready_i = 1'b0;
        issue(6'd5, 64'h500, 64'd3, 64'd3, 12'h040, 1'b1, 64'h580, 4'd8, 1'b0);
        branch_type_i = BR_BNE; issue_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("stall_issue_ready", 64'(issue_ready_o), 64'd0);
            @(posedge clk_i); #1;
        end
        cdb_ready_i = 1'b1;
        issue(6'd1, 64'h600, 64'd3, 64'd4, 12'h004, 1'b0, 64'h0, 4'd9, 1'b0);
        idle(2);

        // Flush with a buffered result and a simultaneous issue
        cdb_ready_i = 1'b0;
        issue(6'd0, 64'h700, 64'd1, 64'd1, 12'h010, 1'b1, 64'h720, 4'd10, 1'b0);
        flush_i = 1'b1; issue_valid_i = 1'b1; pc_i = 64'h800;
        @(posedge clk_i);
        cdb_q.delete(); cdb_seen = 1'b0;
        #1 flush_i = 1'b0; issue_valid_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("flush");
        @(posedge clk_i); #1;

        // Synchronous reset in the middle of a stall
        issue(6'd2, 64'h900, 64'd0, 64'd5, 12'h010, 1'b1, 64'h920, 4'd11, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        cdb_q.delete(); cdb_seen = 1'b0;
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_idle_outputs("midreset");
        check("midreset_rob_idx", 64'(cdb_rob_idx_o), 64'd0);
        check("midreset_except", 64'(cdb_except_o), 64'd0);
        @(posedge clk_i); #1;

        // Randomized traffic under random backpressure
        for (int n = 0; n < 400; n++) begin
            logic [5:0]  t;
            logic [63:0] pc, rs1, rs2, ptgt;
            logic [11:0] imm;
            logic        taken, exc, mis, pt;
            logic [63:0] rtgt;
            t    = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(6, 63)) : 6'($urandom_range(0, 5));
            pc   = {$urandom, $urandom} & ~64'h3;
            if ($urandom_range(0, 7) == 0) pc = pc | 64'h2;
            rs1  = {$urandom, $urandom};
            rs2  = ($urandom_range(0, 2) == 0) ? rs1 : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rs2 = 64'($urandom_range(0, 3));
            imm  = 12'($urandom) & ~12'h1;
            if ($urandom_range(0, 7) == 0) imm = imm | 12'h1;
            pt   = 1'($urandom_range(0, 1));
            model(t, pc, rs1, rs2, imm, pt, 64'h0, taken, rtgt, exc, mis);
            ptgt = ($urandom_range(0, 3) != 0) ? rtgt : {$urandom, $urandom};
            issue(t, pc, rs1, rs2, imm, pt, ptgt, 4'($urandom_range(0, 15)), 1'b1);
            if ($urandom_range(0, 4) == 0) idle(1);
        end

        // Drain and confirm nothing was lost
        cdb_ready_i = 1'b1;
        idle(3);
        check("drain_res_queue", 64'(res_q.size()), 64'd0);
        check("drain_cdb_queue", 64'(cdb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
